// File: rtl/addressgen_seq_if.sv
// Bus between the cycle-type/sprite logic and the VIC address generator / DRAM sequencer.
interface addressgen_seq_if #(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned ADDR_WIDTH  = 14
);
    localparam int unsigned SPR_W = $clog2(NUM_SPRITES);

    logic                       access_start;
    logic [3:0]                 cycle_type;
    logic [2:0]                 cb;
    logic [3:0]                 vm;
    logic [9:0]                 vc;
    logic [2:0]                 rc;
    logic [7:0]                 char_ptr;
    logic                       bmm;
    logic                       ecm;
    logic                       idle;
    logic                       aec;
    logic [1:0]                 ext_bank;
    logic [SPR_W-1:0]           sprite_cnt;
    logic [8*NUM_SPRITES-1:0]   sprite_ptr;
    logic [6*NUM_SPRITES-1:0]   sprite_mc;
    logic                       refresh_reset;
    logic [ADDR_WIDTH-3:0]      ado;
    logic [1:0]                 bank_out;
    logic                       ras_n;
    logic                       cas_n;
    logic                       busy;
    logic [7:0]                 refc;
    logic                       overrun;

    modport master (
        output access_start, cycle_type, cb, vm, vc, rc, char_ptr, bmm, ecm, idle, aec,
               ext_bank, sprite_cnt, sprite_ptr, sprite_mc, refresh_reset,
        input  ado, bank_out, ras_n, cas_n, busy, refc, overrun
    );

    modport slave (
        input  access_start, cycle_type, cb, vm, vc, rc, char_ptr, bmm, ecm, idle, aec,
               ext_bank, sprite_cnt, sprite_ptr, sprite_mc, refresh_reset,
        output ado, bank_out, ras_n, cas_n, busy, refc, overrun
    );
endinterface

// File: rtl/addressgen_seq.sv
// VIC address generator: selects the address from the cycle type, then sequences it
// onto the DRAM pins row-first with RAS/CAS strobes, and keeps the refresh counter.
module addressgen_seq #(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned ROW_BITS    = 8,
    parameter int unsigned ROW_TICKS   = 4,
    parameter int unsigned COL_TICKS   = 6
) (
    input  logic            clk_dot4x,
    input  logic            rst,
    addressgen_seq_if.slave bus
);
    localparam int unsigned SPR_W    = $clog2(NUM_SPRITES);
    localparam int unsigned COL_W    = ADDR_WIDTH - ROW_BITS;
    localparam int unsigned ADO_W    = ADDR_WIDTH - 2;
    localparam int unsigned TICK_MAX = (ROW_TICKS > COL_TICKS) ? ROW_TICKS : COL_TICKS;
    localparam int unsigned CNT_W    = $clog2(TICK_MAX);

    localparam logic [3:0] VIC_LP  = 4'd0;
    localparam logic [3:0] VIC_LS2 = 4'd2;
    localparam logic [3:0] VIC_LR  = 4'd3;
    localparam logic [3:0] VIC_LG  = 4'd4;
    localparam logic [3:0] VIC_HS1 = 4'd5;
    localparam logic [3:0] VIC_HS3 = 4'd8;
    localparam logic [3:0] VIC_HRC = 4'd10;
    localparam logic [3:0] VIC_HGC = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL} state_t;
    typedef enum logic [1:0] {K_NORMAL, K_REFRESH, K_SUPPRESSED} kind_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    kind_t                  kind_q, kind_c;
    logic [13:0]            base_c;
    logic [13:0]            idle_addr_c;
    logic [7:0]             sp_ptr_c;
    logic [5:0]             sp_mc_c;
    logic [ADDR_WIDTH-1:0]  addr_c;
    logic [ROW_BITS-1:0]    col_c;
    logic [ROW_BITS-1:0]    col_q;
    logic [ADO_W-1:0]       ado_q;
    logic [1:0]             bank_q;
    logic                   ras_q, cas_q, busy_q, overrun_q;
    logic [7:0]             refc_q;
    logic                   start_ok, row_to_col, done;

    // Base address selection by cycle type
    always_comb begin
        base_c      = 14'h3FFF;
        kind_c      = K_NORMAL;
        idle_addr_c = bus.ecm ? 14'h39FF : 14'h3FFF;
        sp_ptr_c    = 8'h00;
        sp_mc_c     = 6'h00;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (bus.sprite_cnt == SPR_W'(i)) begin
                sp_ptr_c = bus.sprite_ptr[8*i +: 8];
                sp_mc_c  = bus.sprite_mc[6*i +: 6];
            end
        end
        case (bus.cycle_type)
            VIC_LR: begin
                base_c = {6'b111111, refc_q};
                kind_c = K_REFRESH;
            end
            VIC_LG: begin
                if (bus.idle) begin
                    base_c = idle_addr_c;
                end else begin
                    base_c = bus.bmm ? {bus.cb[2], bus.vc, bus.rc} : {bus.cb, bus.char_ptr, bus.rc};
                    if (bus.ecm) base_c[10:9] = 2'b00;
                end
            end
            VIC_HRC, VIC_HGC: base_c = {bus.vm, bus.vc};
            VIC_LP:           base_c = {bus.vm, 7'h7F, 3'(bus.sprite_cnt)};
            VIC_HS1, VIC_LS2, VIC_HS3: begin
                if (bus.aec) begin
                    base_c = idle_addr_c;
                    kind_c = K_SUPPRESSED;
                end else begin
                    base_c = {sp_ptr_c, sp_mc_c};
                end
            end
            default: ;
        endcase
        addr_c = ADDR_WIDTH'({bus.ext_bank, base_c});
        col_c  = '1;
        col_c[COL_W-1:0] = addr_c[ADDR_WIDTH-1:ROW_BITS];
    end

    // Sequencer next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.access_start) begin
                    state_d = S_ROW;
                    cnt_d   = '0;
                end
            end
            S_ROW: begin
                if (cnt_q == CNT_W'(ROW_TICKS - 1)) begin
                    state_d = S_COL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COL: begin
                if (cnt_q == CNT_W'(COL_TICKS - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign start_ok   = (state_q == S_IDLE) && bus.access_start;
    assign row_to_col = (state_q == S_ROW) && (state_d == S_COL);
    assign done       = (state_q == S_COL) && (state_d == S_IDLE);

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched address, strobes and refresh counter
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            cnt_q     <= '0;
            kind_q    <= K_NORMAL;
            col_q     <= '1;
            ado_q     <= '1;
            bank_q    <= 2'b11;
            ras_q     <= 1'b1;
            cas_q     <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            refc_q    <= 8'hFF;
        end else begin
            cnt_q <= cnt_d;
            if (start_ok) begin
                kind_q <= kind_c;
                col_q  <= col_c;
                ado_q  <= addr_c[ADO_W-1:0];
                bank_q <= addr_c[ADDR_WIDTH-1:ADDR_WIDTH-2];
            end else if (row_to_col) begin
                ado_q[ROW_BITS-1:0] <= col_q;
            end
            // Strobes go low one tick after each phase starts and release on completion
            ras_q  <= ~((state_q != S_IDLE) && (state_d != S_IDLE) && (kind_q != K_SUPPRESSED));
            cas_q  <= ~((state_q == S_COL) && (state_d == S_COL) && (kind_q == K_NORMAL));
            busy_q <= (state_d != S_IDLE);
            if (bus.access_start && (state_q != S_IDLE)) overrun_q <= 1'b1;
            if (bus.refresh_reset) begin
                refc_q <= 8'hFF;
            end else if (done && (kind_q == K_REFRESH)) begin
                refc_q <= refc_q - 8'd1;
            end
        end
    end

    assign bus.ado      = ado_q;
    assign bus.bank_out = bank_q;
    assign bus.ras_n    = ras_q;
    assign bus.cas_n    = cas_q;
    assign bus.busy     = busy_q;
    assign bus.refc     = refc_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_addressgen_seq.sv
// Bench for addressgen_seq: a 14-bit default instance and a 16-bit minimum-tick instance
// share stimulus and are checked against a tick-offset reference model.
module tb_addressgen_seq;
    localparam int T_LP = 0, T_LS2 = 2, T_LR = 3, T_LG = 4, T_HS1 = 5, T_HS3 = 8;
    localparam int T_HRC = 10, T_HGC = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        access_start = 1'b0;
    logic [3:0]  cycle_type = '0;
    logic [2:0]  cb = '0;
    logic [3:0]  vm = '0;
    logic [9:0]  vc = '0;
    logic [2:0]  rc = '0;
    logic [7:0]  char_ptr = '0;
    logic        bmm = 1'b0, ecm = 1'b0, idle = 1'b0, aec = 1'b0;
    logic [1:0]  ext_bank = '0;
    logic [2:0]  sprite_cnt = '0;
    logic [63:0] sprite_ptr = '0;
    logic [47:0] sprite_mc = '0;
    logic        refresh_reset = 1'b0;

    int total = 0;
    int bad = 0;
    bit armed = 1'b0;

    int m_active[2], m_off[2], m_addr[2], m_kind[2], m_refc[2], m_ovr[2], m_ado[2], m_bank[2];

    always #5 clk = ~clk;

    addressgen_seq_if #(.NUM_SPRITES(8), .ADDR_WIDTH(14)) b0 ();
    addressgen_seq_if #(.NUM_SPRITES(8), .ADDR_WIDTH(16)) b1 ();

    assign b0.access_start = access_start;   assign b1.access_start = access_start;
    assign b0.cycle_type = cycle_type;       assign b1.cycle_type = cycle_type;
    assign b0.cb = cb;                       assign b1.cb = cb;
    assign b0.vm = vm;                       assign b1.vm = vm;
    assign b0.vc = vc;                       assign b1.vc = vc;
    assign b0.rc = rc;                       assign b1.rc = rc;
    assign b0.char_ptr = char_ptr;           assign b1.char_ptr = char_ptr;
    assign b0.bmm = bmm;                     assign b1.bmm = bmm;
    assign b0.ecm = ecm;                     assign b1.ecm = ecm;
    assign b0.idle = idle;                   assign b1.idle = idle;
    assign b0.aec = aec;                     assign b1.aec = aec;
    assign b0.ext_bank = ext_bank;           assign b1.ext_bank = ext_bank;
    assign b0.sprite_cnt = sprite_cnt;       assign b1.sprite_cnt = sprite_cnt;
    assign b0.sprite_ptr = sprite_ptr;       assign b1.sprite_ptr = sprite_ptr;
    assign b0.sprite_mc = sprite_mc;         assign b1.sprite_mc = sprite_mc;
    assign b0.refresh_reset = refresh_reset; assign b1.refresh_reset = refresh_reset;

    addressgen_seq #(.ADDR_WIDTH(14)) dut0 (.clk_dot4x(clk), .rst(rst), .bus(b0.slave));
    addressgen_seq #(.ADDR_WIDTH(16), .ROW_TICKS(2), .COL_TICKS(3))
        dut1 (.clk_dot4x(clk), .rst(rst), .bus(b1.slave));

    function automatic int aw_of(input int i);  return (i == 0) ? 14 : 16; endfunction
    function automatic int rt_of(input int i);  return (i == 0) ? 4 : 2;   endfunction
    function automatic int ct_of(input int i);  return (i == 0) ? 6 : 3;   endfunction

    function automatic int row_of(input int a, input int aw);
        return a & ((1 << (aw - 2)) - 1);
    endfunction

    function automatic int col_of(input int a, input int aw);
        int f;
        f = (a >> 8) | ((32'hFF << (aw - 8)) & 32'hFF);
        return (row_of(a, aw) & ~32'hFF) | f;
    endfunction

    function automatic int model_base(input int refc_v);
        int idle_a, a, sc;
        idle_a = ecm ? 32'h39FF : 32'h3FFF;
        sc = int'(sprite_cnt);
        case (int'(cycle_type))
            T_LR: return 32'h3F00 + refc_v;
            T_LG: begin
                if (idle) return idle_a;
                if (bmm) a = int'(cb[2]) * 8192 + int'(vc) * 8 + int'(rc);
                else     a = int'(cb) * 2048 + int'(char_ptr) * 8 + int'(rc);
                if (ecm) a = a & ~32'h600;
                return a;
            end
            T_HRC, T_HGC: return int'(vm) * 1024 + int'(vc);
            T_LP: return int'(vm) * 1024 + 32'h7F * 8 + sc;
            T_HS1, T_LS2, T_HS3: begin
                if (aec) return idle_a;
                return int'((sprite_ptr >> (8 * sc)) & 64'hFF) * 64 + int'((sprite_mc >> (6 * sc)) & 48'h3F);
            end
            default: return 32'h3FFF;
        endcase
    endfunction

    // Predict instance i's visible state right after the coming clock edge
    task automatic model_edge(input int i);
        int aw, r, c, full, kind;
        bit was_active, fin;
        aw = aw_of(i); r = rt_of(i); c = ct_of(i);
        if (rst) begin
            m_active[i] = 0; m_off[i] = 0; m_ovr[i] = 0; m_refc[i] = 255;
            m_ado[i] = (1 << (aw - 2)) - 1; m_bank[i] = 3; m_kind[i] = 0;
            return;
        end
        full = model_base(m_refc[i]) | ((int'(ext_bank) & ((1 << (aw - 14)) - 1)) << 14);
        kind = (int'(cycle_type) == T_LR) ? 1 :
               ((int'(cycle_type) inside {T_HS1, T_LS2, T_HS3}) && aec) ? 2 : 0;
        was_active = (m_active[i] != 0);
        fin = 1'b0;
        if (was_active) begin
            m_off[i]++;
            if (m_off[i] == r + c) begin
                m_active[i] = 0;
                fin = 1'b1;
            end
        end
        if (refresh_reset) m_refc[i] = 255;
        else if (fin && m_kind[i] == 1) m_refc[i] = (m_refc[i] + 255) % 256;
        if (access_start) begin
            if (was_active) begin
                m_ovr[i] = 1;
            end else begin
                m_active[i] = 1; m_off[i] = 0; m_addr[i] = full; m_kind[i] = kind;
                m_bank[i] = full >> (aw - 2);
            end
        end
        if (m_active[i] != 0)
            m_ado[i] = (m_off[i] < r) ? row_of(m_addr[i], aw) : col_of(m_addr[i], aw);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(posedge clk) begin
        #1;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                int e_ras, e_cas;
                e_ras = (m_active[i] != 0 && m_off[i] >= 1 && m_kind[i] != 2) ? 0 : 1;
                e_cas = (m_active[i] != 0 && m_off[i] >= rt_of(i) + 1 && m_kind[i] == 0) ? 0 : 1;
                chk(i == 0 ? "d14_ado" : "d16_ado", i == 0 ? int'(b0.ado) : int'(b1.ado), m_ado[i]);
                chk(i == 0 ? "d14_bank" : "d16_bank", i == 0 ? int'(b0.bank_out) : int'(b1.bank_out), m_bank[i]);
                chk(i == 0 ? "d14_ras" : "d16_ras", i == 0 ? int'(b0.ras_n) : int'(b1.ras_n), e_ras);
                chk(i == 0 ? "d14_cas" : "d16_cas", i == 0 ? int'(b0.cas_n) : int'(b1.cas_n), e_cas);
                chk(i == 0 ? "d14_busy" : "d16_busy", i == 0 ? int'(b0.busy) : int'(b1.busy), m_active[i]);
                chk(i == 0 ? "d14_refc" : "d16_refc", i == 0 ? int'(b0.refc) : int'(b1.refc), m_refc[i]);
                chk(i == 0 ? "d14_ovr" : "d16_ovr", i == 0 ? int'(b0.overrun) : int'(b1.overrun), m_ovr[i]);
            end
        end
    end

    task automatic step();
        model_edge(0);
        model_edge(1);
        armed = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_pulse();
        access_start = 1'b1;
        step();
        access_start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        repeat (2) step();
        rst = 1'b0;
        chk("rst_ado", int'(b0.ado), 32'hFFF);
        chk("rst_refc", int'(b0.refc), 32'hFF);

        // LG character fetch
        cycle_type = 4'(T_LG); cb = 3'b010; char_ptr = 8'h41; rc = 3'd3;
        start_pulse();
        chk("lg_row", int'(b0.ado), 32'h20B);
        chk("lg_bank", int'(b0.bank_out), 1);
        chk("lg_ras_k", int'(b0.ras_n), 1);
        step();
        chk("lg_ras_k1", int'(b0.ras_n), 0);
        repeat (3) step();
        chk("lg_col", int'(b0.ado), 32'h2D2);
        chk("lg_cas_k4", int'(b0.cas_n), 1);
        step();
        chk("lg_cas_k5", int'(b0.cas_n), 0);
        repeat (4) step();
        chk("lg_ras_k9", int'(b0.ras_n), 0);
        chk("lg_cas_k9", int'(b0.cas_n), 0);
        step();
        chk("lg_busy_k10", int'(b0.busy), 0);
        chk("lg_ras_k10", int'(b0.ras_n), 1);

        // Same fetch in ECM mode
        ecm = 1'b1;
        start_pulse();
        chk("ecm_row", int'(b0.ado), 32'h00B);
        repeat (4) step();
        chk("ecm_col", int'(b0.ado), 32'h0D0);
        repeat (6) step();

        // Refresh: one access, full wrap, and reset colliding with completion
        ecm = 1'b0;
        refresh_reset = 1'b1; step(); refresh_reset = 1'b0;
        cycle_type = 4'(T_LR);
        start_pulse();
        chk("lr_row", int'(b0.ado), 32'hFFF);
        repeat (10) step();
        chk("lr_refc1", int'(b0.refc), 32'hFE);
        for (int n = 1; n < 256; n++) begin
            start_pulse();
            repeat (10) step();
        end
        chk("lr_wrap14", int'(b0.refc), 32'hFF);
        chk("lr_wrap16", int'(b1.refc), 32'hFF);
        start_pulse();
        repeat (9) step();
        refresh_reset = 1'b1; step(); refresh_reset = 1'b0;
        chk("lr_collide", int'(b0.refc), 32'hFF);

        // Sprite accesses, suppressed then real
        cycle_type = 4'(T_HS1); aec = 1'b1;
        start_pulse();
        chk("spr_sup_row", int'(b0.ado), 32'hFFF);
        repeat (9) step();
        chk("spr_sup_busy", int'(b0.busy), 1);
        step();
        chk("spr_sup_done", int'(b0.busy), 0);
        aec = 1'b0; sprite_cnt = 3'd5; sprite_ptr[47:40] = 8'hA7; sprite_mc[35:30] = 6'h15;
        start_pulse();
        chk("spr_row", int'(b0.ado), 32'h9D5);
        chk("spr_bank", int'(b0.bank_out), 2);
        repeat (4) step();
        chk("spr_col", int'(b0.ado), 32'h9E9);
        repeat (6) step();

        // Wide address with external bank
        cycle_type = 4'(T_HRC); vm = 4'h3; vc = 10'h155; ext_bank = 2'b10;
        start_pulse();
        chk("w16_row", int'(b1.ado), 32'h0D55);
        chk("w16_bank", int'(b1.bank_out), 2);
        chk("w14_bank", int'(b0.bank_out), 0);
        repeat (2) step();
        chk("w16_col", int'(b1.ado), 32'h0D8D);
        repeat (8) step();

        // Overrun cases and mid-access reset
        start_pulse();
        repeat (2) step();
        start_pulse();
        chk("ovr_k3", int'(b0.overrun), 1);
        repeat (7) step();
        chk("ovr_done", int'(b0.busy), 0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("ovr_clr", int'(b0.overrun), 0);
        start_pulse();
        repeat (9) step();
        start_pulse();
        chk("ovr_k10", int'(b0.overrun), 1);
        repeat (6) step();
        rst = 1'b1; step(); rst = 1'b0;
        start_pulse();
        repeat (5) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("abort_ras", int'(b0.ras_n), 1);
        chk("abort_cas", int'(b0.cas_n), 1);
        chk("abort_ovr", int'(b0.overrun), 0);

        // Randomized traffic
        repeat (3000) begin
            cycle_type    = 4'($urandom);
            cb            = 3'($urandom);
            vm            = 4'($urandom);
            vc            = 10'($urandom);
            rc            = 3'($urandom);
            char_ptr      = 8'($urandom);
            bmm           = 1'($urandom);
            ecm           = 1'($urandom);
            idle          = 1'($urandom);
            aec           = 1'($urandom);
            ext_bank      = 2'($urandom);
            sprite_cnt    = 3'($urandom);
            sprite_ptr    = {$urandom, $urandom};
            sprite_mc     = 48'({$urandom, $urandom});
            access_start  = ($urandom_range(0, 3) == 0);
            refresh_reset = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            step();
        end
        access_start = 1'b0;
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
